// File: rtl/decode_buffer_ctrl.sv
// decode_buffer_ctrl: circular instruction buffer between fetch packets and a multi-slot decode group,
// with single-cycle flush and asynchronous reset.
module decode_buffer_ctrl #(
    parameter int DECODE_NUM = 4,
    parameter int DEPTH      = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         fe_valid,
    input  logic [2:0]                   fe_num,
    input  logic [DECODE_NUM-1:0][31:0]  fe_instr,
    output logic                         fe_ready,
    output logic [DECODE_NUM-1:0][31:0]  de_instr,
    output logic [DECODE_NUM-1:0]        de_valid,
    input  logic [2:0]                   de_accept,
    output logic [$clog2(DEPTH):0]       count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int NW = (CW > 3) ? CW : 3;
    typedef enum logic {NORMAL, FLUSH} state_t;
    state_t state;
    logic [31:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [NW-1:0] avail, n_wr, n_rd;
    logic wr_en;
    always_comb begin
        fe_ready = (state == NORMAL) && (CW'(DEPTH) - count >= CW'(DECODE_NUM));
        wr_en    = fe_valid && fe_ready && !flush;
        avail    = (state != NORMAL) ? '0 : (NW'(count) < NW'(DECODE_NUM)) ? NW'(count) : NW'(DECODE_NUM);
        n_wr     = !wr_en ? '0 : (NW'(fe_num) < NW'(DECODE_NUM)) ? NW'(fe_num) : NW'(DECODE_NUM);
        // de_accept beyond the visible slots is clamped so occupancy never underflows
        n_rd     = flush ? '0 : (NW'(de_accept) < avail) ? NW'(de_accept) : avail;
    end
    always_comb begin
        for (int k = 0; k < DECODE_NUM; k++) begin
            de_instr[k] = mem[rd_ptr + AW'(k)];
            de_valid[k] = (state == NORMAL) && (CW'(k) < count);
        end
    end
    always_ff @(posedge clk) begin
        for (int k = 0; k < DECODE_NUM; k++)
            if (wr_en && NW'(k) < n_wr)
                mem[wr_ptr + AW'(k)] <= fe_instr[k];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= NORMAL;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            state  <= FLUSH;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            state  <= NORMAL;
            rd_ptr <= rd_ptr + AW'(n_rd);
            wr_ptr <= wr_ptr + AW'(n_wr);
            count  <= count + CW'(n_wr) - CW'(n_rd);
        end
    end
endmodule

// File: tb/tb_decode_buffer_ctrl.sv
// tb_decode_buffer_ctrl: directed stimulus with a queue scoreboard; the monitor checks every cycle
// against the queued instruction stream and applies the cycle's pops and pushes.
module tb_decode_buffer_ctrl;
    localparam int DN = 4;
    localparam int DEPTH = 8;
    logic clk = 0;
    logic rst_n = 0;
    logic flush = 0;
    logic fe_valid = 0;
    logic [2:0] fe_num = 0;
    logic [DN-1:0][31:0] fe_instr = '0;
    logic fe_ready;
    logic [DN-1:0][31:0] de_instr;
    logic [DN-1:0] de_valid;
    logic [2:0] de_accept = 0;
    logic [3:0] count;
    int tests = 0;
    int fails = 0;
    int popped = 0;
    logic [31:0] q[$];
    logic fl = 0;

    decode_buffer_ctrl #(.DECODE_NUM(DN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .fe_valid(fe_valid), .fe_num(fe_num),
        .fe_instr(fe_instr), .fe_ready(fe_ready), .de_instr(de_instr), .de_valid(de_valid),
        .de_accept(de_accept), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: q holds the instructions the buffer should contain, oldest first.
    always @(negedge clk) begin
        int nv, nr, nw;
        logic exp_ready;
        if (!rst_n) begin
            q.delete();
            fl = 0;
        end
        exp_ready = !fl && (DEPTH - q.size() >= DN);
        chk("mon_count", 32'(count), 32'(q.size()));
        chk("mon_fe_ready", 32'(fe_ready), 32'(exp_ready));
        for (int k = 0; k < DN; k++) begin
            chk("mon_de_valid", 32'(de_valid[k]), 32'(!fl && k < q.size()));
            if (!fl && k < q.size()) chk("mon_de_instr", de_instr[k], q[k]);
        end
        if (rst_n) begin
            if (flush) begin
                q.delete();
                fl = 1;
            end else begin
                nv = (q.size() < DN) ? q.size() : DN;
                nr = (int'(de_accept) < nv) ? int'(de_accept) : nv;
                for (int k = 0; k < nr; k++) begin
                    void'(q.pop_front());
                    popped++;
                end
                if (fe_valid && exp_ready) begin
                    nw = (int'(fe_num) < DN) ? int'(fe_num) : DN;
                    for (int k = 0; k < nw; k++) q.push_back(fe_instr[k]);
                end
                fl = 0;
            end
        end
    end

    task automatic drive(input logic v, input logic [2:0] n, input logic [31:0] base,
                         input logic [2:0] acc, input logic f);
        fe_valid = v;
        fe_num = n;
        for (int k = 0; k < DN; k++) fe_instr[k] = base + 32'(k);
        de_accept = acc;
        flush = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int sent, pkt, n, iter;
        logic ok;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_de_valid", 32'(de_valid), 0);
        chk("rst_fe_ready", 32'(fe_ready), 1);
        rst_n = 1;
        drive(1, 4, 32'hA000_0000, 0, 0);
        chk("a_count", 32'(count), 4);
        chk("a_de_valid", 32'(de_valid), 32'hF);
        chk("a_fe_ready", 32'(fe_ready), 1);
        for (int k = 0; k < DN; k++) chk("a_de_instr", de_instr[k], 32'hA000_0000 + 32'(k));
        drive(1, 4, 32'hB000_0000, 0, 0);
        chk("b_count", 32'(count), 8);
        chk("b_fe_ready", 32'(fe_ready), 0);
        drive(1, 4, 32'hC000_0000, 0, 0);
        chk("c_held_count", 32'(count), 8);
        drive(1, 4, 32'hC000_0000, 4, 0);
        chk("c_drain_count", 32'(count), 4);
        chk("c_drain_instr0", de_instr[0], 32'hB000_0000);
        chk("c_drain_instr3", de_instr[3], 32'hB000_0003);
        drive(1, 4, 32'hC000_0000, 0, 0);
        chk("c_written_count", 32'(count), 8);
        drive(0, 0, 0, 4, 0);
        drive(0, 0, 0, 4, 0);
        chk("drain_count", 32'(count), 0);
        drive(1, 3, 32'hD000_0000, 0, 0);
        chk("d_count", 32'(count), 3);
        drive(1, 2, 32'hE000_0000, 3, 0);
        chk("rw_count", 32'(count), 2);
        chk("rw_de_valid", 32'(de_valid), 32'h3);
        chk("rw_instr0", de_instr[0], 32'hE000_0000);
        chk("rw_instr1", de_instr[1], 32'hE000_0001);
        drive(0, 0, 0, 4, 0);
        drive(1, 1, 32'hF000_0000, 0, 0);
        chk("one_count", 32'(count), 1);
        drive(0, 0, 0, 4, 0);
        chk("clamp_count", 32'(count), 0);
        chk("clamp_de_valid", 32'(de_valid), 0);
        drive(0, 0, 0, 3, 0);
        chk("empty_accept_count", 32'(count), 0);
        popped = 0;
        sent = 0;
        pkt = 0;
        iter = 0;
        while (sent < 20 && iter < 200) begin
            n = (pkt % 2 == 0) ? 3 : 1;
            if (n > 20 - sent) n = 20 - sent;
            fe_valid = 1;
            fe_num = 3'(n);
            for (int k = 0; k < DN; k++) fe_instr[k] = 32'h5000_0000 + 32'(sent + k);
            de_accept = 2;
            flush = 0;
            ok = fe_ready;
            @(posedge clk);
            #1;
            if (ok) begin
                sent += n;
                pkt++;
            end
            iter++;
        end
        chk("wrap_sent", 32'(sent), 20);
        fe_valid = 0;
        iter = 0;
        while (count != 0 && iter < 50) begin
            @(posedge clk);
            #1;
            iter++;
        end
        chk("wrap_drained", 32'(count), 0);
        @(negedge clk);
        chk("wrap_popped", 32'(popped), 20);
        @(posedge clk);
        #1;
        drive(1, 4, 32'h6000_0000, 0, 0);
        drive(1, 2, 32'h6000_0004, 0, 0);
        chk("pre_flush_count", 32'(count), 6);
        drive(1, 4, 32'h7000_0000, 0, 1);
        chk("flush_count", 32'(count), 0);
        chk("flush_de_valid", 32'(de_valid), 0);
        chk("flush_fe_ready", 32'(fe_ready), 0);
        drive(0, 0, 0, 0, 0);
        chk("post_flush_ready", 32'(fe_ready), 1);
        chk("post_flush_count", 32'(count), 0);
        drive(1, 2, 32'h8000_0000, 0, 0);
        chk("post_flush_instr0", de_instr[0], 32'h8000_0000);
        chk("post_flush_de_valid", 32'(de_valid), 32'h3);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
        chk("flush_hold_ready", 32'(fe_ready), 0);
        drive(0, 0, 0, 0, 0);
        chk("flush_exit_ready", 32'(fe_ready), 1);
        drive(1, 4, 32'h9000_0000, 0, 0);
        chk("pre_rst_count", 32'(count), 4);
        fe_valid = 1;
        fe_num = 4;
        de_accept = 2;
        rst_n = 0;
        #1;
        chk("async_rst_count", 32'(count), 0);
        chk("async_rst_de_valid", 32'(de_valid), 0);
        chk("async_rst_fe_ready", 32'(fe_ready), 1);
        @(posedge clk);
        #1;
        fe_valid = 0;
        de_accept = 0;
        rst_n = 1;
        @(posedge clk);
        #1;
        chk("after_rst_count", 32'(count), 0);
        chk("after_rst_de_valid", 32'(de_valid), 0);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/decode_buffer_ctrl.md
DECODE_BUFFER_CTRL -- requirements
Module: decode_buffer_ctrl

Interface
REQ-001 SHALL have parameters (one per line: name, default, meaning):
 DECODE_NUM, 4, instructions per fetch packet / decode group
 DEPTH, 8, buffer entries; power of 2, >= 2*DECODE_NUM
REQ-002 SHALL have ports (one per line: name direction width meaning):
 clk  input  1  single clock, rising edge
 rst_n  input  1  reset, asynchronous, active-low
 flush  input  1  pipeline redirect; discard all buffered instructions
 fe_valid  input  1  fetch packet present
 fe_num  input  3  count of valid slots in packet, slots 0..fe_num-1, slot 0 oldest
 fe_instr  input  32 x DECODE_NUM  fetch packet instructions
 fe_ready  output  1  buffer can take a full packet this cycle
 de_instr  output  32 x DECODE_NUM  oldest buffered instructions, slot 0 oldest
 de_valid  output  DECODE_NUM  thermometer mask of valid de_instr slots
 de_accept  input  3  instructions consumed by decode this cycle
 count  output  log2(DEPTH)+1  current occupancy

Function
REQ-003 SHALL store instructions in a DEPTH-entry circular buffer with registered rd_ptr, wr_ptr (log2(DEPTH) bits, wrap modulo DEPTH) and count.
REQ-004 SHALL implement FSM states NORMAL and FLUSH; reset state NORMAL.
REQ-005 fe_ready SHALL equal (state==NORMAL) && (DEPTH-count >= DECODE_NUM), computed from registered state only.
REQ-006 Write occurs iff fe_valid && fe_ready; writes min(fe_num,DECODE_NUM) instructions at wr_ptr..wr_ptr+n-1 in slot order; fe_num=0 writes nothing.
REQ-007 fe_instr/fe_num SHALL be ignored when write does not occur; fetch must hold the packet until fe_ready.
REQ-008 de_instr[k] SHALL be buffer[(rd_ptr+k) mod DEPTH]; de_valid[k]=(k<count) && (state==NORMAL).
REQ-009 Read pops min(de_accept, popcount(de_valid)) entries; de_accept above popcount is clamped, never underflows.
REQ-010 Simultaneous read and write in one cycle: count_next = count + n_wr - n_rd; both pointers advance.
REQ-011 No write-to-read bypass: instruction written at edge N is first visible on de_valid after edge N.
REQ-012 Order SHALL be preserved: instructions leave in exactly the order they entered, across pointer wrap.
REQ-013 flush=1 in any state: at next edge rd_ptr=wr_ptr=0, count=0, state=FLUSH; same-cycle write and read are discarded.
REQ-014 FLUSH lasts one cycle (fe_ready=0, de_valid=0), then NORMAL; flush asserted during FLUSH keeps FLUSH.
REQ-015 count SHALL never exceed DEPTH and never go below 0.

Reset
REQ-016 rst_n=0 SHALL asynchronously force rd_ptr=0, wr_ptr=0, count=0, state=NORMAL; buffer contents need no reset.
REQ-017 During and after reset: de_valid=0, count=0, fe_ready=1 (DEPTH>=DECODE_NUM).
REQ-018 Reset mid-operation SHALL discard all entries with no partial read/write completing at the reset edge.

Verification
REQ-019 Reset, then fe_valid=1, fe_num=4, instr A0..A3, de_accept=0 -> next cycle count=4, de_valid=4'b1111, de_instr=A0..A3, fe_ready=1.
REQ-020 Second packet B0..B3 with de_accept=0 -> count=8, fe_ready=0; third packet C0..C3 held, not written until de_accept=4 drains, then de_instr=B0..B3.
REQ-021 count=3, fe_num=2 write and de_accept=3 same cycle -> count=2, de_instr slots 0..1 = new instructions, de_valid=4'b0011.
REQ-022 Wrap: stream 20 instructions via fe_num alternating 3/1 with de_accept=2 -> output sequence identical to input order, count never >8.
REQ-023 count=6, flush=1 with fe_valid=1 -> next cycle count=0, de_valid=0, fe_ready=0; following cycle fe_ready=1, no old instruction reappears.
REQ-024 count=1, de_accept=4 -> count=0, no underflow; rst_n pulsed low mid-stream -> count=0, de_valid=0 immediately (asynchronous).
